// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and bit-count helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;
  localparam int KP_KEYS = KP_ROWS * KP_COLS;

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED     = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set.
  function automatic logic [3:0] low_index16(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      idx = v[i] ? 4'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_core.sv
// Row driver and column sampler: synchronises the columns, walks the rows and
// assembles a 16-bit snapshot of closed keys with a strobe once it is complete.
module keypad_scan_core
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KP_COLS-1:0]   col_n,
  output logic [KP_ROWS-1:0]   row_n,
  output logic [KP_KEYS-1:0]   snapshot,
  output logic                 scan_end
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  logic [KP_COLS-1:0] col_meta_r;
  logic [KP_COLS-1:0] col_sync_r;
  logic [DW-1:0]      dwell_r;
  logic [1:0]         row_r;
  logic [KP_ROWS-1:0] row_n_r;
  logic [KP_KEYS-1:0] snapshot_r;
  logic               scan_end_r;
  logic               sample_s;
  logic [1:0]         row_next_s;

  assign sample_s   = (dwell_r == DWELL_LAST);
  assign row_next_s = row_r + 2'd1;

  // Two-flop synchroniser for the asynchronous column inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Dwell and row counters; the row drive moves only after its sample is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_r <= DWELL_ZERO;
      row_r   <= 2'd0;
      row_n_r <= 4'b1110;
    end else if (sample_s) begin
      dwell_r <= DWELL_ZERO;
      row_r   <= row_next_s;
      row_n_r <= ~(4'b0001 << row_next_s);
    end else begin
      dwell_r <= dwell_r + DWELL_ONE;
    end
  end

  // Snapshot capture and end-of-scan strobe (strobe lags so the row-3 bits are in place)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot_r <= 16'h0000;
      scan_end_r <= 1'b0;
    end else begin
      if (sample_s) begin
        snapshot_r[{row_r, 2'b00} +: 4] <= ~col_sync_r;
      end else begin
        snapshot_r <= snapshot_r;
      end
      scan_end_r <= sample_s && (row_r == 2'd3);
    end
  end

  assign row_n    = row_n_r;
  assign snapshot = snapshot_r;
  assign scan_end = scan_end_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: classifies each completed scan and debounces
// presses and releases over whole scans, reporting one key code per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] COL_N,
  output logic [3:0] ROW_N,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CW-1:0] STAB_ZERO = CW'(0);
  localparam logic [CW-1:0] STAB_ONE  = CW'(1);
  localparam logic [CW-1:0] STAB_DONE = CW'(DEBOUNCE_SCANS);
  localparam bit            DIRECT    = (DEBOUNCE_SCANS == 1);

  logic [KP_KEYS-1:0] snapshot_s;
  logic               scan_end_s;
  logic [4:0]         pop_s;
  logic               none_s;
  logic               one_s;
  logic [3:0]         idx_s;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [3:0]    cand_r;
  logic [3:0]    cand_nxt_s;
  logic [CW-1:0] stab_r;
  logic [CW-1:0] stab_nxt_s;
  logic [CW-1:0] stab_inc_s;

  logic          press_s;
  logic          held_nxt_s;
  logic [3:0]    code_nxt_s;
  logic [3:0]    key_code_r;
  logic          key_valid_r;
  logic          key_held_r;

  keypad_scan_core #(
    .SCAN_DIV (SCAN_DIV)
  ) u_core (
    .clk      (CLK),
    .rst      (RST),
    .col_n    (COL_N),
    .row_n    (ROW_N),
    .snapshot (snapshot_s),
    .scan_end (scan_end_s)
  );

  assign pop_s      = popcount16(snapshot_s);
  assign none_s     = (pop_s == 5'd0);
  assign one_s      = (pop_s == 5'd1);
  assign idx_s      = low_index16(snapshot_s);
  assign stab_inc_s = stab_r + STAB_ONE;

  // State, candidate and stability counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cand_r  <= 4'd0;
      stab_r  <= STAB_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cand_r  <= cand_nxt_s;
      stab_r  <= stab_nxt_s;
    end
  end

  // Next-state logic, evaluated only on scan-end
  always_comb begin
    state_nxt_s = state_r;
    cand_nxt_s  = cand_r;
    stab_nxt_s  = stab_r;
    if (scan_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (one_s) begin
            cand_nxt_s  = idx_s;
            stab_nxt_s  = STAB_ONE;
            state_nxt_s = DIRECT ? ST_PRESSED : ST_DEB_PRESS;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DEB_PRESS: begin
          if (one_s && (idx_s == cand_r)) begin
            stab_nxt_s  = stab_inc_s;
            state_nxt_s = (stab_inc_s == STAB_DONE) ? ST_PRESSED : ST_DEB_PRESS;
          end else if (one_s) begin
            cand_nxt_s  = idx_s;
            stab_nxt_s  = STAB_ONE;
          end else begin
            stab_nxt_s  = STAB_ZERO;
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (none_s) begin
            stab_nxt_s  = STAB_ONE;
            state_nxt_s = DIRECT ? ST_IDLE : ST_DEB_RELEASE;
          end else begin
            state_nxt_s = ST_PRESSED;
          end
        end
        ST_DEB_RELEASE: begin
          if (none_s) begin
            stab_nxt_s  = stab_inc_s;
            state_nxt_s = (stab_inc_s == STAB_DONE) ? ST_IDLE : ST_DEB_RELEASE;
          end else begin
            stab_nxt_s  = STAB_ZERO;
            state_nxt_s = ST_PRESSED;
          end
        end
        default: begin
          stab_nxt_s  = STAB_ZERO;
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: a pulse only on a debounced press, never on a bounced release
  always_comb begin
    press_s    = 1'b0;
    code_nxt_s = key_code_r;
    held_nxt_s = 1'b0;
    if ((state_nxt_s == ST_PRESSED) &&
        ((state_r == ST_IDLE) || (state_r == ST_DEB_PRESS))) begin
      press_s    = 1'b1;
      code_nxt_s = cand_nxt_s;
    end else begin
      press_s    = 1'b0;
    end
    if ((state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_DEB_RELEASE)) begin
      held_nxt_s = 1'b1;
    end else begin
      held_nxt_s = 1'b0;
    end
  end

  // Registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      key_code_r  <= code_nxt_s;
      key_valid_r <= press_s;
      key_held_r  <= held_nxt_s;
    end
  end

  assign KEY_CODE  = key_code_r;
  assign KEY_VALID = key_valid_r;
  assign KEY_HELD  = key_held_r;

endmodule
